atm_ledger_arbiter: RTL and testbench

Shares one account-balance ledger memory among NUM_REQ ATM terminal front-ends. Requests are arbitrated round-robin, and each granted transaction (inquiry, deposit or withdraw) is sequenced through a read-check-write cycle on the ledger. Results are returned on a shared response bus with a one-hot done pulse. Sits between the per-terminal ATM FSMs and the single-port ledger RAM, so that the FSMs no longer own balance storage.

---
 rtl/atm_ledger_arbiter.sv | 158 +++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter: round-robin arbiter that lets NUM_REQ ATM terminals
// share one single-port balance ledger. Each granted transaction runs a
// read-check-write sequence and reports on a shared response bus.
module atm_ledger_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 4,
  parameter int DATA_W       = 32,
  parameter int NUM_ACCOUNTS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [ID_W*NUM_REQ-1:0]   req_card,
  input  logic [DATA_W*NUM_REQ-1:0] req_amount,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [1:0]                resp_err,
  output logic [DATA_W-1:0]         resp_balance,
  output logic                      busy,
  output logic                      mem_rd_en,
  output logic                      mem_wr_en,
  output logic [ID_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] E_OK   = 2'b00;
  localparam logic [1:0] E_CARD = 2'b01;
  localparam logic [1:0] E_INS  = 2'b10;
  localparam logic [1:0] E_REQ  = 2'b11;

  logic [2:0]         state;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gidx, ptr;
  logic [1:0]         op_q;
  logic [ID_W-1:0]    card_q;
  logic [DATA_W-1:0]  amt_q, bal;
  logic [1:0]         res_err;
  logic [DATA_W-1:0]  res_bal;

  logic               pick_vld;
  logic [PTR_W-1:0]   pick;
  logic [1:0]         pick_op;
  logic [ID_W-1:0]    pick_card;
  logic [DATA_W-1:0]  pick_amt;
  logic               pick_card_ok;

  logic [DATA_W:0]    sum;
  logic [1:0]         ex_err;
  logic [DATA_W-1:0]  ex_bal, ex_wdata;
  logic               ex_wr;

  // Round-robin pick: scan downward so the lowest offset from ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick     = PTR_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign pick_op      = req_op[2*int'(pick) +: 2];
  assign pick_card    = req_card[ID_W*int'(pick) +: ID_W];
  assign pick_amt     = req_amount[DATA_W*int'(pick) +: DATA_W];
  assign pick_card_ok = (pick_card != '0) && (int'(pick_card) < NUM_ACCOUNTS);

  // Balance check on the captured ledger value; overflow seen in the carry bit.
  always_comb begin
    sum      = {1'b0, bal} + {1'b0, amt_q};
    ex_err   = E_OK;
    ex_bal   = bal;
    ex_wr    = 1'b0;
    ex_wdata = bal;
    case (op_q)
      2'b01: begin
        if (amt_q == '0 || sum[DATA_W]) ex_err = E_REQ;
        else begin
          ex_wr    = 1'b1;
          ex_wdata = sum[DATA_W-1:0];
          ex_bal   = sum[DATA_W-1:0];
        end
      end
      2'b10: begin
        if (amt_q == '0)      ex_err = E_REQ;
        else if (amt_q > bal) ex_err = E_INS;
        else begin
          ex_wr    = 1'b1;
          ex_wdata = bal - amt_q;
          ex_bal   = bal - amt_q;
        end
      end
      default: ;
    endcase
  end

  // Transaction sequencer: accept, read, wait for RAM, execute, report.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      gnt     <= '0;
      gidx    <= '0;
      ptr     <= '0;
      op_q    <= '0;
      card_q  <= '0;
      amt_q   <= '0;
      bal     <= '0;
      res_err <= E_OK;
      res_bal <= '0;
    end else begin
      case (state)
        S_IDLE: if (pick_vld) begin
          gnt     <= NUM_REQ'(1) << pick;
          gidx    <= pick;
          op_q    <= pick_op;
          card_q  <= pick_card;
          amt_q   <= pick_amt;
          res_bal <= '0;
          res_err <= E_OK;
          if (!pick_card_ok)          begin res_err <= E_CARD; state <= S_DONE; end
          else if (pick_op == 2'b11)  begin res_err <= E_REQ;  state <= S_DONE; end
          else                        state <= S_RD;
        end
        S_RD:   state <= S_WAIT;
        S_WAIT: begin bal <= mem_rdata; state <= S_EXEC; end
        S_EXEC: begin res_err <= ex_err; res_bal <= ex_bal; state <= S_DONE; end
        S_DONE: begin
          gnt   <= '0;
          ptr   <= (gidx == PTR_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write and done are also gated by rst so an aborting reset cycle
  // never commits a balance or reports completion.
  assign busy         = (state != S_IDLE);
  assign grant        = gnt;
  assign done         = (state == S_DONE && rst) ? gnt : '0;
  assign resp_err     = (state == S_DONE) ? res_err : E_OK;
  assign resp_balance = (state == S_DONE) ? res_bal : '0;
  assign mem_rd_en    = (state == S_RD);
  assign mem_wr_en    = (state == S_EXEC) && ex_wr && rst;
  assign mem_addr     = (mem_rd_en || mem_wr_en) ? card_q : '0;
  assign mem_wdata    = mem_wr_en ? ex_wdata : '0;
endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench for atm_ledger_arbiter with a behavioural ledger RAM.
module tb_atm_ledger_arbiter;
  localparam int NR = 4, IW = 4, DW = 32, NA = 6;

  logic clk = 1'b0, rst = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [2*NR-1:0]  req_op = '0;
  logic [IW*NR-1:0] req_card = '0;
  logic [DW*NR-1:0] req_amount = '0;
  logic [NR-1:0]    grant, done;
  logic [1:0]       resp_err;
  logic [DW-1:0]    resp_balance, mem_wdata, mem_rdata;
  logic             busy, mem_rd_en, mem_wr_en;
  logic [IW-1:0]    mem_addr;

  atm_ledger_arbiter #(.NUM_REQ(NR), .ID_W(IW), .DATA_W(DW), .NUM_ACCOUNTS(NA)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_card(req_card),
    .req_amount(req_amount), .grant(grant), .done(done), .resp_err(resp_err),
    .resp_balance(resp_balance), .busy(busy), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  // Ledger RAM model: registered read, write-on-strobe.
  logic [DW-1:0] ledger [0:15];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ledger[mem_addr];
    if (mem_wr_en) ledger[mem_addr] <= mem_wdata;
  end

  typedef struct { int idx; logic [1:0] err; logic [DW-1:0] bal; } resp_t;
  typedef struct { logic [IW-1:0] addr; logic [DW-1:0] data; } wr_t;
  resp_t sbq[$];
  wr_t   wq[$];
  int tests = 0, fails = 0, rd_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected responses/writes whenever the DUT presents them.
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (rst) begin
      chk("rd_wr_exclusive", 64'(mem_rd_en & mem_wr_en), 64'd0);
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    end
    if (mem_wr_en) begin
      if (wq.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.addr));
        chk("wr_data", 64'(mem_wdata), 64'(w.data));
      end
    end
    if (done != '0) begin
      if (sbq.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        resp_t r;
        r = sbq.pop_front();
        chk("done_vec", 64'(done), 64'(4'b1 << r.idx));
        chk("resp_err", 64'(resp_err), 64'(r.err));
        chk("resp_bal", 64'(resp_balance), 64'(r.bal));
      end
    end
  end

  task automatic txn(input int idx, input logic [1:0] op, input logic [IW-1:0] card,
                     input logic [DW-1:0] amt, input logic [1:0] e_err,
                     input logic [DW-1:0] e_bal, input int e_lat, input bit e_wr,
                     input logic [DW-1:0] e_wd);
    int n, wr_cyc, rd0;
    bit seen;
    resp_t r;
    r.idx = idx; r.err = e_err; r.bal = e_bal;
    sbq.push_back(r);
    if (e_wr) begin wr_t w; w.addr = card; w.data = e_wd; wq.push_back(w); end
    @(posedge clk); #1;
    req_op[2*idx +: 2]      = op;
    req_card[IW*idx +: IW]  = card;
    req_amount[DW*idx +: DW] = amt;
    req[idx] = 1'b1;
    rd0 = rd_cnt;
    @(posedge clk);              // accept edge, cycle 0
    #1 req_amount[DW*idx +: DW] = ~amt;  // captured values must be used
    n = 0; seen = 0; wr_cyc = -1;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      chk("grant_held", 64'(grant), 64'(4'b1 << idx));
      if (mem_wr_en) wr_cyc = n;
      if (done != '0) seen = 1;
    end
    chk("latency", 64'(n), 64'(e_lat));
    req[idx] = 1'b0;
    chk("write_cycle", 64'(wr_cyc), e_wr ? 64'(3) : 64'(-1));
    @(posedge clk); #1;
    if (e_lat == 1) chk("no_read", 64'(rd_cnt - rd0), 64'd0);
    else            chk("one_read", 64'(rd_cnt - rd0), 64'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ledger[i] = '0;
    for (int i = 1; i < 5; i++) ledger[i] = 32'(i * 1111);
    ledger[5] = 32'hFFFF_FFFF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_bal", 64'(resp_balance), 64'd0);
    chk("rst_mem", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 64'd0);
    rst = 1'b1;

    //  idx op     card   amt    err    bal          lat wr  wdata
    txn(0, 2'b00, 4'd3, 32'd0,    2'b00, 32'd3333,    4, 0, 32'd0);
    txn(1, 2'b01, 4'd2, 32'd500,  2'b00, 32'd2722,    4, 1, 32'd2722);
    txn(2, 2'b01, 4'd5, 32'd1,    2'b11, 32'hFFFFFFFF, 4, 0, 32'd0);
    txn(3, 2'b10, 4'd4, 32'd4445, 2'b10, 32'd4444,    4, 0, 32'd0);
    txn(0, 2'b10, 4'd4, 32'd4444, 2'b00, 32'd0,       4, 1, 32'd0);
    txn(1, 2'b10, 4'd1, 32'd0,    2'b11, 32'd1111,    4, 0, 32'd0);
    txn(2, 2'b00, 4'd0, 32'd0,    2'b01, 32'd0,       1, 0, 32'd0);
    txn(3, 2'b00, 4'd7, 32'd0,    2'b01, 32'd0,       1, 0, 32'd0);
    txn(0, 2'b11, 4'd1, 32'd5,    2'b11, 32'd0,       1, 0, 32'd0);
    chk("ledger2", 64'(ledger[2]), 64'd2722);
    chk("ledger4", 64'(ledger[4]), 64'd0);

    // Round robin with all requests held; reset first to return ptr to 0
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      resp_t r;
      r.idx = k % 4; r.err = 2'b00; r.bal = 32'd3333;
      sbq.push_back(r);
    end
    for (int i = 0; i < NR; i++) begin
      req_op[2*i +: 2] = 2'b00; req_card[IW*i +: IW] = 4'd3; req_amount[DW*i +: DW] = '0;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (done == '0 && n < 30);
      chk("rr_done_seen", 64'(n < 30), 64'd1);
      chk("rr_grant_order", 64'(grant), 64'(4'b1 << (k % 4)));
      if (k == 4) req = '0;
      else begin
        @(negedge clk);
        chk("rr_idle_gap", 64'({busy, grant}), 64'd0);
        @(negedge clk);
        chk("rr_next_grant", 64'(grant), 64'(4'b1 << ((k + 1) % 4)));
      end
    end
    @(negedge clk);
    chk("rr_idle_after", 64'(busy), 64'd0);

    // Reset during EXEC of a deposit: no write, no done
    @(posedge clk); #1;
    req_op[3:2] = 2'b01; req_card[7:4] = 4'd1; req_amount[63:32] = 32'd10;
    req[1] = 1'b1;
    repeat (3) @(posedge clk);   // accept, RD->WAIT, WAIT->EXEC
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_no_wr", 64'(mem_wr_en), 64'd0);
    chk("abort_no_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_outs", 64'({grant, done, resp_err, mem_rd_en, mem_wr_en, mem_addr}), 64'd0);
    chk("abort_data", 64'(resp_balance | mem_wdata), 64'd0);
    chk("abort_ledger", 64'(ledger[1]), 64'd1111);
    req = '0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 64'(busy), 64'd0);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
